// File: rtl/arr_table_ctrl.sv
// Register-table controller: sequenced default load after reset or soft_init,
// then round-robin shared access for two requesters with per-entry write protect.
module arr_table_ctrl #(
    parameter int unsigned          DW       = 8,
    parameter int unsigned          DEPTH    = 4,
    parameter int unsigned          AW       = $clog2(DEPTH),
    parameter logic [DEPTH*DW-1:0]  INIT_VAL = {8'd40, 8'd30, 8'd20, 8'd10},
    parameter logic [DEPTH-1:0]     EN_INIT  = 4'b1101
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             soft_init,
    input  logic             a_valid,
    input  logic             a_we,
    input  logic [AW-1:0]    a_addr,
    input  logic [DW-1:0]    a_wdata,
    output logic             a_ready,
    input  logic             b_valid,
    input  logic             b_we,
    input  logic [AW-1:0]    b_addr,
    input  logic [DW-1:0]    b_wdata,
    output logic             b_ready,
    output logic             rsp_valid,
    output logic             rsp_id,
    output logic [DW-1:0]    rsp_rdata,
    output logic             rsp_err,
    input  logic             en_we,
    input  logic [DEPTH-1:0] en_wdata,
    output logic [DEPTH-1:0] entry_en,
    output logic             init_busy
);

    localparam logic [0:0] ST_INIT_WALK = 1'b0;
    localparam logic [0:0] ST_SERVE     = 1'b1;

    logic [DW-1:0]    table_q [DEPTH];
    logic [DW-1:0]    table_d [DEPTH];
    logic [0:0]       state_q, state_d;
    logic [AW-1:0]    idx_q, idx_d;
    logic [DEPTH-1:0] en_q, en_d;
    logic             last_b_q, last_b_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             rsp_id_q, rsp_id_d;
    logic [DW-1:0]    rsp_rdata_q, rsp_rdata_d;
    logic             rsp_err_q, rsp_err_d;

    logic             serve_ok;
    logic             pick_b;
    logic             acc;
    logic             sel_we;
    logic [AW-1:0]    sel_addr;
    logic [DW-1:0]    sel_wdata;
    logic [DW-1:0]    init_word;

    // last_b_q=1 means B won the previous accept, so A takes the next tie.
    always_comb begin
        serve_ok  = (state_q == ST_SERVE) && !soft_init;
        pick_b    = b_valid && (!a_valid || !last_b_q);
        a_ready   = serve_ok && a_valid && !pick_b;
        b_ready   = serve_ok && b_valid && pick_b;
        acc       = a_ready || b_ready;
        sel_we    = pick_b ? b_we    : a_we;
        sel_addr  = pick_b ? b_addr  : a_addr;
        sel_wdata = pick_b ? b_wdata : a_wdata;
    end

    always_comb begin
        init_word = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (idx_q == AW'(i)) begin
                init_word = INIT_VAL[i*DW +: DW];
            end
        end
    end

    always_comb begin
        table_d     = table_q;
        state_d     = state_q;
        idx_d       = idx_q;
        en_d        = en_we ? en_wdata : en_q;
        last_b_d    = last_b_q;
        rsp_valid_d = acc;
        rsp_id_d    = rsp_id_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        if (soft_init) begin
            state_d = ST_INIT_WALK;
            idx_d   = '0;
        end else if (state_q == ST_INIT_WALK) begin
            table_d[idx_q] = init_word;
            idx_d          = idx_q + AW'(1);
            if (idx_q == AW'(DEPTH - 1)) begin
                state_d = ST_SERVE;
            end
        end

        // Accept sees the mask as it stood before any same-cycle en_we load.
        if (acc) begin
            last_b_d    = pick_b;
            rsp_id_d    = pick_b;
            rsp_rdata_d = table_q[sel_addr];
            rsp_err_d   = sel_we && !en_q[sel_addr];
            if (sel_we && en_q[sel_addr]) begin
                table_d[sel_addr] = sel_wdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= '0;
            end
            state_q     <= ST_INIT_WALK;
            idx_q       <= '0;
            en_q        <= EN_INIT;
            last_b_q    <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                table_q[i] <= table_d[i];
            end
            state_q     <= state_d;
            idx_q       <= idx_d;
            en_q        <= en_d;
            last_b_q    <= last_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign entry_en  = en_q;
    assign init_busy = (state_q == ST_INIT_WALK);

endmodule

// File: tb/tb_arr_table_ctrl.sv
// Directed bench for arr_table_ctrl: init walk, arbitration, write protect,
// mask timing, soft_init and asynchronous reset.
module tb_arr_table_ctrl;

    logic       clk;
    logic       reset_n;
    logic       soft_init;
    logic       a_valid, a_we, a_ready;
    logic [1:0] a_addr;
    logic [7:0] a_wdata;
    logic       b_valid, b_we, b_ready;
    logic [1:0] b_addr;
    logic [7:0] b_wdata;
    logic       rsp_valid, rsp_id, rsp_err;
    logic [7:0] rsp_rdata;
    logic       en_we;
    logic [3:0] en_wdata;
    logic [3:0] entry_en;
    logic       init_busy;

    int checks   = 0;
    int failures = 0;

    arr_table_ctrl #(
        .DW       (8),
        .DEPTH    (4),
        .INIT_VAL ({8'd40, 8'd30, 8'd20, 8'd10}),
        .EN_INIT  (4'b1101)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .soft_init (soft_init),
        .a_valid   (a_valid),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ready   (b_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .en_we     (en_we),
        .en_wdata  (en_wdata),
        .entry_en  (entry_en),
        .init_busy (init_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one request, wait (bounded) for ready, then check the response.
    task automatic xact(input bit id, input bit we, input int unsigned addr,
                        input int unsigned wd, input int unsigned exp_rd,
                        input bit exp_err, input string tag);
        int n;
        logic rdy;
        if (id) begin
            b_valid = 1'b1; b_we = we; b_addr = addr[1:0]; b_wdata = wd[7:0];
        end else begin
            a_valid = 1'b1; a_we = we; a_addr = addr[1:0]; a_wdata = wd[7:0];
        end
        #1;
        n = 0;
        rdy = id ? b_ready : a_ready;
        while (!rdy && n < 20) begin
            @(negedge clk); #1;
            rdy = id ? b_ready : a_ready;
            n++;
        end
        check({tag, "_rdy"}, 32'(rdy), 32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
        @(negedge clk); #1;
        check({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"},  32'(rsp_id),    32'(id));
        check({tag, "_rd"},  32'(rsp_rdata), exp_rd);
        check({tag, "_err"}, 32'(rsp_err),   32'(exp_err));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; soft_init = 1'b0;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 2'd2; a_wdata = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
        en_we = 1'b0; en_wdata = '0;

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy",  32'(init_busy), 32'd1);
        check("rst_ardy",  32'(a_ready),   32'd0);
        check("rst_vld",   32'(rsp_valid), 32'd0);
        check("rst_id",    32'(rsp_id),    32'd0);
        check("rst_err",   32'(rsp_err),   32'd0);
        check("rst_rd",    32'(rsp_rdata), 32'd0);
        check("rst_en",    32'(entry_en),  32'hD);

        // Test 1: init walk timing with A pending, then read all entries
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("walk_busy%0d", i), 32'(init_busy), 32'd1);
            check($sformatf("walk_ardy%0d", i), 32'(a_ready),   32'd0);
        end
        @(negedge clk); #1;
        check("walk_done_busy", 32'(init_busy), 32'd0);
        check("walk_done_ardy", 32'(a_ready),   32'd1);
        @(posedge clk); #1;
        a_valid = 1'b0;
        @(negedge clk); #1;
        check("t1_vld", 32'(rsp_valid), 32'd1);
        check("t1_rd",  32'(rsp_rdata), 32'd30);
        check("t1_id",  32'(rsp_id),    32'd0);
        xact(1'b0, 1'b0, 0, 0, 10, 1'b0, "t1_r0");
        xact(1'b1, 1'b0, 1, 0, 20, 1'b0, "t1_r1");
        xact(1'b0, 1'b0, 2, 0, 30, 1'b0, "t1_r2");
        xact(1'b1, 1'b0, 3, 0, 40, 1'b0, "t1_r3");

        // Test 2: both valid every cycle, B won last so A leads
        a_valid = 1'b1; a_we = 1'b0; a_addr = 2'd0;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 2'd1;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) begin
                @(negedge clk);
            end
            #1;
            if (k > 0) begin
                check($sformatf("rr_id%0d", k - 1), 32'(rsp_id),    32'((k - 1) % 2));
                check($sformatf("rr_rd%0d", k - 1), 32'(rsp_rdata), ((k - 1) % 2 == 0) ? 32'd10 : 32'd20);
            end
            check($sformatf("rr_ardy%0d", k), 32'(a_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check($sformatf("rr_brdy%0d", k), 32'(b_ready), (k % 2 == 1) ? 32'd1 : 32'd0);
        end
        @(negedge clk); #1;
        check("rr_id3", 32'(rsp_id),    32'd1);
        check("rr_rd3", 32'(rsp_rdata), 32'd20);
        a_valid = 1'b0;
        b_valid = 1'b0;

        // Test 3: enabled write, read-after-write, protected write
        xact(1'b0, 1'b1, 2, 8'hAA, 30, 1'b0, "t3_w2");
        xact(1'b0, 1'b0, 2, 0, 8'hAA, 1'b0, "t3_r2");
        xact(1'b0, 1'b1, 1, 8'h77, 20, 1'b1, "t3_w1");
        xact(1'b0, 1'b0, 1, 0, 20, 1'b0, "t3_r1");

        // Test 4: mask load coinciding with a write accept
        check("t4_en_old", 32'(entry_en), 32'hD);
        a_valid = 1'b1; a_we = 1'b1; a_addr = 2'd1; a_wdata = 8'h66;
        en_we = 1'b1; en_wdata = 4'b1111;
        #1;
        check("t4_rdy", 32'(a_ready), 32'd1);
        @(posedge clk); #1;
        en_we = 1'b0;
        a_valid = 1'b0;
        @(negedge clk); #1;
        check("t4_err_same", 32'(rsp_err),  32'd1);
        check("t4_en_new",   32'(entry_en), 32'hF);
        xact(1'b0, 1'b1, 1, 8'h66, 20, 1'b0, "t4_w1");
        xact(1'b0, 1'b0, 1, 0, 8'h66, 1'b0, "t4_r1");

        // Test 5: soft_init with B pending
        xact(1'b0, 1'b1, 0, 8'h55, 10, 1'b0, "t5_w0");
        b_valid = 1'b1; b_we = 1'b0; b_addr = 2'd0;
        soft_init = 1'b1;
        #1;
        check("t5_si_brdy", 32'(b_ready), 32'd0);
        @(posedge clk); #1;
        soft_init = 1'b0;
        for (int j = 0; j < 4; j++) begin
            @(negedge clk); #1;
            check($sformatf("t5_brdy%0d", j), 32'(b_ready),   32'd0);
            check($sformatf("t5_busy%0d", j), 32'(init_busy), 32'd1);
        end
        @(negedge clk); #1;
        check("t5_brdy_after", 32'(b_ready),  32'd1);
        check("t5_en_kept",    32'(entry_en), 32'hF);
        xact(1'b1, 1'b0, 0, 0, 10, 1'b0, "t5_r0");

        // Test 6: asynchronous reset mid-walk
        xact(1'b0, 1'b1, 2, 8'h99, 30, 1'b0, "t6_w2");
        soft_init = 1'b1;
        @(posedge clk); #1;
        soft_init = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); #1;
        check("t6_busy_pre", 32'(init_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("t6_en_rst",  32'(entry_en),  32'hD);
        check("t6_vld_rst", 32'(rsp_valid), 32'd0);
        check("t6_rd_rst",  32'(rsp_rdata), 32'd0);
        check("t6_busy",    32'(init_busy), 32'd1);
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk); #1;
            check($sformatf("t6_walk%0d", i), 32'(init_busy), 32'd1);
        end
        xact(1'b0, 1'b0, 0, 0, 10, 1'b0, "t6_r0");
        xact(1'b1, 1'b0, 1, 0, 20, 1'b0, "t6_r1");
        xact(1'b0, 1'b0, 2, 0, 30, 1'b0, "t6_r2");
        xact(1'b1, 1'b0, 3, 0, 40, 1'b0, "t6_r3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
